// File: rtl/i2s_adc_capture.sv
// I2S ADC receiver: oversamples BCLK/LRCK/ADCDAT in the i_clk domain and
// delivers left/right sample pairs, flagging half-frames cut short by LRCK.
`timescale 1ns/1ps
module i2s_adc_capture #(
   parameter int DATA_W = 16,
   parameter int SLOT_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_bclk,
   input  logic              i_lrclk,
   input  logic              i_adcdat,
   output logic [DATA_W-1:0] o_left,
   output logic [DATA_W-1:0] o_right,
   output logic              o_valid,
   output logic              o_frame_err,
   output logic [7:0]        o_err_cnt
);
   localparam int CNT_W = $clog2(SLOT_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [2:0]        meta_r;        // {bclk, lrclk, adcdat}
   logic [2:0]        sync_r;
   logic              bclk_prev_r;
   logic              lr_prev_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] shreg_r;
   logic [DATA_W-1:0] pend_r;
   logic              pend_ok_r;
   logic              chan_r;
   logic              rise_s;
   logic              lr_edge_s;
   logic              shift_s;
   logic              word_done_s;
   logic              trunc_s;
   logic              start_s;
   logic [DATA_W-1:0] shreg_next_s;

   assign rise_s       = sync_r[2] & ~bclk_prev_r;
   assign lr_edge_s    = rise_s & (sync_r[1] != lr_prev_r);
   assign shreg_next_s = {shreg_r[DATA_W-2:0], sync_r[0]};

   // Three identical 2-flop synchronizers keep bclk, lrclk and data aligned
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meta_r      <= 3'b000;
         sync_r      <= 3'b000;
         bclk_prev_r <= 1'b0;
         lr_prev_r   <= 1'b0;
      end else begin
         meta_r      <= {i_bclk, i_lrclk, i_adcdat};
         sync_r      <= meta_r;
         bclk_prev_r <= sync_r[2];
         if (rise_s) begin
            lr_prev_r <= sync_r[1];
         end
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state; the rise carrying the LRCK change is the I2S delay bit, so
   // the first rise handled in DELAY already carries the MSB
   always_comb begin
      state_next_s = state_r;
      shift_s      = 1'b0;
      word_done_s  = 1'b0;
      trunc_s      = 1'b0;
      start_s      = 1'b0;
      if (rise_s) begin
         case (state_r)
            IDLE: begin
               if (lr_edge_s && !sync_r[1]) begin
                  start_s      = 1'b1;
                  state_next_s = DELAY;
               end else begin
                  state_next_s = IDLE;
               end
            end
            DELAY, SHIFT: begin
               if (lr_edge_s) begin
                  trunc_s      = 1'b1;
                  start_s      = 1'b1;
                  state_next_s = DELAY;
               end else begin
                  shift_s = 1'b1;
                  if (cnt_r == CNT_W'(DATA_W - 1)) begin
                     word_done_s  = 1'b1;
                     state_next_s = HOLD;
                  end else begin
                     state_next_s = SHIFT;
                  end
               end
            end
            HOLD: begin
               if (lr_edge_s) begin
                  start_s      = 1'b1;
                  state_next_s = DELAY;
               end else begin
                  state_next_s = HOLD;
               end
            end
            default: begin
               state_next_s = IDLE;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Bit counter, shift register, channel tag and pending left word
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         shreg_r   <= {DATA_W{1'b0}};
         chan_r    <= 1'b0;
         pend_r    <= {DATA_W{1'b0}};
         pend_ok_r <= 1'b0;
      end else begin
         if (start_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {DATA_W{1'b0}};
            chan_r  <= sync_r[1];
         end else if (shift_s) begin
            cnt_r   <= cnt_r + CNT_W'(1);
            shreg_r <= shreg_next_s;
         end
         if (trunc_s) begin
            pend_ok_r <= 1'b0;
         end else if (word_done_s && !chan_r) begin
            pend_r    <= shreg_next_s;
            pend_ok_r <= 1'b1;
         end else if (word_done_s) begin
            pend_ok_r <= 1'b0;
         end
      end
   end

   // Registered outputs: pair strobe, truncation strobe, saturating error count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_left      <= {DATA_W{1'b0}};
         o_right     <= {DATA_W{1'b0}};
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_err_cnt   <= 8'd0;
      end else begin
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         if (word_done_s && chan_r && pend_ok_r) begin
            o_left  <= pend_r;
            o_right <= shreg_next_s;
            o_valid <= 1'b1;
         end
         if (trunc_s) begin
            o_frame_err <= 1'b1;
            if (o_err_cnt != 8'hFF) begin
               o_err_cnt <= o_err_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_adc_capture.sv
// Randomized bench for i2s_adc_capture: a half-frame level reference model
// predicts sample pairs and truncation errors from the I2S framing rules.
`timescale 1ns/1ps
module tb_i2s_adc_capture;
   localparam int DW = 16;
   localparam int SW = 32;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          bclk   = 1'b0;
   logic          lrclk  = 1'b0;
   logic          adcdat = 1'b0;
   logic [DW-1:0] left;
   logic [DW-1:0] right;
   logic          valid;
   logic          ferr;
   logic [7:0]    ecnt;

   i2s_adc_capture #(.DATA_W(DW), .SLOT_W(SW)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_bclk     (bclk),
      .i_lrclk    (lrclk),
      .i_adcdat   (adcdat),
      .o_left     (left),
      .o_right    (right),
      .o_valid    (valid),
      .o_frame_err(ferr),
      .o_err_cnt  (ecnt)
   );

   always #41.667 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   longint        cyc = 0;
   logic [DW-1:0] obs_l[$];
   logic [DW-1:0] obs_r[$];
   longint        obs_t[$];
   int            ferr_pulses = 0;
   int            dbl_pulse = 0;
   int            unstable = 0;
   logic          prev_valid = 1'b0;
   logic          prev_ferr = 1'b0;
   logic [DW-1:0] hold_l = '0;
   logic [DW-1:0] hold_r = '0;

   // reference model state
   logic [DW-1:0] exp_l[$];
   logic [DW-1:0] exp_r[$];
   bit            m_armed, m_pend_ok, m_last_lr, m_done;
   logic [DW-1:0] m_pend;
   int            m_err = 0;
   int            m_trunc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_valid <= valid;
      prev_ferr  <= ferr;
      hold_l     <= left;
      hold_r     <= right;
      if (valid) begin
         obs_l.push_back(left);
         obs_r.push_back(right);
         obs_t.push_back(cyc);
      end
      if (ferr) ferr_pulses <= ferr_pulses + 1;
      if ((valid && prev_valid) || (ferr && prev_ferr)) dbl_pulse <= dbl_pulse + 1;
      if (!rst && !valid && (left !== hold_l || right !== hold_r)) unstable <= unstable + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_armed   = 1'b0;
      m_pend_ok = 1'b0;
      m_last_lr = 1'b0;
      m_done    = 1'b1;
      m_err     = 0;
   endfunction

   // One half-frame of len BCLK periods: delay bit, then len-1 data bits
   function automatic void model_half(input bit lr, input int len, input logic [DW-1:0] word);
      bit edge_seen;
      edge_seen = (lr != m_last_lr);
      m_last_lr = lr;
      if (edge_seen) begin
         if (m_armed && !m_done) begin
            m_trunc++;
            if (m_err < 255) m_err++;
            m_pend_ok = 1'b0;
         end
         if (!m_armed && !lr) m_armed = 1'b1;
         if (m_armed) begin
            m_done = (len - 1 >= DW);
            if (m_done && !lr) begin
               m_pend    = word;
               m_pend_ok = 1'b1;
            end else if (m_done) begin
               if (m_pend_ok) begin
                  exp_l.push_back(m_pend);
                  exp_r.push_back(word);
               end
               m_pend_ok = 1'b0;
            end
         end
      end
   endfunction

   task automatic send_half(input bit lr, input int len, input logic [DW-1:0] word);
      model_half(lr, len, word);
      for (int k = 0; k < len; k++) begin
         bclk = 1'b0;
         if (k == 0) lrclk = lr;
         if (k >= 1 && k <= DW) adcdat = word[DW-k];
         else adcdat = 1'($urandom_range(0, 1));
         repeat (4) @(negedge clk);
         bclk = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
      send_half(1'b0, SW, l);
      send_half(1'b1, SW, r);
   endtask

   task automatic finish_scen(input string tag, input int base);
      bclk = 1'b0;
      repeat (24) @(negedge clk);
      check_val({tag, " pairs"}, 64'(obs_l.size()), 64'(exp_l.size()));
      for (int i = base; i < exp_l.size() && i < obs_l.size(); i++) begin
         check_val($sformatf("%s left%0d", tag, i), 64'(obs_l[i]), 64'(exp_l[i]));
         check_val($sformatf("%s right%0d", tag, i), 64'(obs_r[i]), 64'(exp_r[i]));
      end
      check_val({tag, " ferr"}, 64'(ferr_pulses), 64'(m_trunc));
      check_val({tag, " errcnt"}, 64'(ecnt), 64'(m_err));
   endtask

   task automatic do_reset(input string tag);
      bclk = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val({tag, " rst outs"}, {22'd0, valid, ferr, ecnt, left, right}, 64'd0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int base;
      logic [DW-1:0] lv[4];
      logic [DW-1:0] rv[4];
      model_reset();
      repeat (4) @(negedge clk);
      check_val("init rst outs", {22'd0, valid, ferr, ecnt, left, right}, 64'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // frame with no preceding 1->0 edge is ignored, next one captured
      base = exp_l.size();
      send_half(1'b0, SW, 16'($urandom));
      send_half(1'b1, SW, 16'($urandom));
      repeat (24) @(negedge clk);
      check_val("noedge pairs", 64'(obs_l.size()), 64'd0);
      check_val("noedge outs", {32'd0, left, right}, 64'd0);
      send_frame(16'h8000, 16'h7FFF);
      finish_scen("noedge", base);
      check_val("noedge final", {32'd0, left, right}, 64'h8000_7FFF);

      // basic frame
      base = exp_l.size();
      send_frame(16'h1234, 16'hABCD);
      finish_scen("basic", base);
      check_val("basic outs", {32'd0, left, right}, 64'h1234_ABCD);
      check_val("basic noerr", 64'(ferr_pulses), 64'd0);

      // left truncated after 10 bits, then a good frame
      base = exp_l.size();
      send_half(1'b0, 11, 16'($urandom));
      send_half(1'b1, SW, 16'($urandom));
      send_frame(16'h0F0F, 16'hC3A5);
      finish_scen("trunc", base);
      check_val("trunc errcnt1", 64'(ecnt), 64'd1);

      // 300 truncated half-frames saturate the counter
      base = exp_l.size();
      for (int i = 0; i < 300; i++) send_half(1'(i % 2), 4, 16'($urandom));
      send_frame(16'($urandom), 16'($urandom));
      finish_scen("sat", base);
      check_val("sat 255", 64'(ecnt), 64'd255);

      // reset in the middle of a right word
      base = exp_l.size();
      send_frame(16'($urandom), 16'($urandom));
      send_half(1'b0, SW, 16'($urandom));
      send_half(1'b1, 8, 16'($urandom));
      do_reset("midright");
      send_half(1'b1, 20, 16'($urandom));
      send_frame(16'h5A5A, 16'hA5A5);
      finish_scen("midright", base);
      check_val("midright outs", {32'd0, left, right}, 64'h5A5A_A5A5);

      // four back-to-back frames, 512 cycles apart
      base = exp_l.size();
      for (int i = 0; i < 4; i++) begin
         lv[i] = 16'(($urandom & 32'hFFF0) | i);
         rv[i] = 16'(($urandom & 32'hFFF0) | (i + 8));
         send_frame(lv[i], rv[i]);
      end
      finish_scen("b2b", base);
      check_val("b2b count", 64'(obs_l.size() - base), 64'd4);
      for (int i = base + 1; i < obs_t.size(); i++)
         check_val($sformatf("b2b gap%0d", i), 64'(obs_t[i] - obs_t[i-1]), 64'd512);

      // random half-frame lengths and data
      base = exp_l.size();
      for (int i = 0; i < 30; i++) send_half(~lrclk, $urandom_range(1, SW), 16'($urandom));
      send_frame(16'($urandom), 16'($urandom));
      finish_scen("rand", base);

      check_val("single-cycle strobes", 64'(dbl_pulse), 64'd0);
      check_val("outs stable", 64'(unstable), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
